// File: rtl/image_stream_processor.sv
// image_stream_processor: two-stage valid/ready pipeline applying a per-pixel point
// operation to a multi-channel stream, tracking frame position and tagging SOF/EOL/EOF.
module image_stream_processor #(
    parameter int unsigned CH_W       = 8,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             operation_select,
    input  logic [CH_W-1:0]        threshold_value,
    input  logic [CH_W-1:0]        brightness_value,
    input  logic                   pixel_valid_in,
    output logic                   pixel_ready_out,
    input  logic [NUM_CH*CH_W-1:0] pixel_in,
    output logic                   pixel_valid_out,
    input  logic                   pixel_ready_in,
    output logic [NUM_CH*CH_W-1:0] pixel_out,
    output logic                   pixel_sof_out,
    output logic                   pixel_eol_out,
    output logic                   pixel_eof_out,
    output logic [15:0]            frame_count
);
    localparam int unsigned PW = NUM_CH * CH_W;
    localparam int unsigned XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned GW = CH_W + 8;
    localparam logic [CH_W-1:0] CH_MAX = {CH_W{1'b1}};

    localparam logic [2:0] OP_INVERT = 3'b000;
    localparam logic [2:0] OP_THRESH = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_GRAY   = 3'b011;
    localparam logic [2:0] OP_SUB    = 3'b100;
    localparam logic [2:0] OP_PASS   = 3'b101;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [2:0]      op_q;
    logic [CH_W-1:0] thr_q, bright_q;

    logic                         v1_q;
    logic [PW-1:0]                s1_pix_q;
    logic [2:0]                   s1_op_q;
    logic                         s1_sof_q, s1_eol_q, s1_eof_q;
    logic [NUM_CH-1:0][CH_W:0]    s1_sum_q, s1_diff_q;
    logic [NUM_CH-1:0]            s1_thr_q;
    logic [GW-1:0]                s1_gray_q;

    logic in_acc, adv, out_acc;
    logic at_sof, at_eol, at_eof;
    logic [2:0]      cfg_op;
    logic [CH_W-1:0] cfg_thr, cfg_bright;
    logic [NUM_CH-1:0][CH_W:0] sum_d, diff_d;
    logic [NUM_CH-1:0]         thr_d;
    logic [GW-1:0]             gray_d;
    logic [PW-1:0]             final_d;
    logic [CH_W-1:0]           res;

    assign pixel_ready_out = ~v1_q | ~pixel_valid_out | pixel_ready_in;
    assign in_acc  = pixel_valid_in & pixel_ready_out;
    assign adv     = ~pixel_valid_out | pixel_ready_in;
    assign out_acc = pixel_valid_out & pixel_ready_in;

    assign at_sof = (x_q == '0) && (y_q == '0);
    assign at_eol = (x_q == XW'(IMG_WIDTH - 1));
    assign at_eof = at_eol && (y_q == YW'(IMG_HEIGHT - 1));

    // The first pixel of a frame already uses the config being latched with it.
    assign cfg_op     = at_sof ? operation_select : op_q;
    assign cfg_thr    = at_sof ? threshold_value  : thr_q;
    assign cfg_bright = at_sof ? brightness_value : bright_q;

    // Stage-1 per-channel sums, differences and threshold compares
    always_comb begin
        sum_d  = '0;
        diff_d = '0;
        thr_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_d[c]  = {1'b0, pixel_in[PW-1-c*CH_W -: CH_W]} + {1'b0, cfg_bright};
            diff_d[c] = {1'b0, pixel_in[PW-1-c*CH_W -: CH_W]} - {1'b0, cfg_bright};
            thr_d[c]  = pixel_in[PW-1-c*CH_W -: CH_W] >= cfg_thr;
        end
    end

    // Weighted luma sum; the >>8 happens in stage 2 by taking the upper CH_W bits.
    if (NUM_CH == 3) begin : g_luma
        assign gray_d = GW'(77)  * GW'(pixel_in[PW-1 -: CH_W])
                      + GW'(150) * GW'(pixel_in[PW-1-CH_W -: CH_W])
                      + GW'(29)  * GW'(pixel_in[PW-1-2*CH_W -: CH_W]);
    end else begin : g_copy
        assign gray_d = {pixel_in[PW-1 -: CH_W], 8'd0};
    end

    // Stage-2 result selection and saturation
    always_comb begin
        final_d = '0;
        res     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            res = s1_pix_q[PW-1-c*CH_W -: CH_W];
            case (s1_op_q)
                OP_INVERT: res = CH_MAX - s1_pix_q[PW-1-c*CH_W -: CH_W];
                OP_THRESH: res = s1_thr_q[c] ? CH_MAX : '0;
                OP_ADD:    res = s1_sum_q[c][CH_W] ? CH_MAX : s1_sum_q[c][CH_W-1:0];
                OP_GRAY:   res = s1_gray_q[GW-1 -: CH_W];
                OP_SUB:    res = s1_diff_q[c][CH_W] ? '0 : s1_diff_q[c][CH_W-1:0];
                default:   res = s1_pix_q[PW-1-c*CH_W -: CH_W];
            endcase
            final_d[PW-1-c*CH_W -: CH_W] = res;
        end
    end

    // Frame position, config shadow and emitted-frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            op_q        <= OP_PASS;
            thr_q       <= '0;
            bright_q    <= '0;
            frame_count <= '0;
        end else begin
            if (in_acc) begin
                if (at_eol) begin
                    x_q <= '0;
                    y_q <= at_eof ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
                if (at_sof) begin
                    op_q     <= operation_select;
                    thr_q    <= threshold_value;
                    bright_q <= brightness_value;
                end
            end
            if (out_acc && pixel_eof_out) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Stage 1: capture accepted pixel, markers and partial results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_pix_q  <= '0;
            s1_op_q   <= OP_PASS;
            s1_sof_q  <= 1'b0;
            s1_eol_q  <= 1'b0;
            s1_eof_q  <= 1'b0;
            s1_sum_q  <= '0;
            s1_diff_q <= '0;
            s1_thr_q  <= '0;
            s1_gray_q <= '0;
        end else if (in_acc) begin
            v1_q      <= 1'b1;
            s1_pix_q  <= pixel_in;
            s1_op_q   <= cfg_op;
            s1_sof_q  <= at_sof;
            s1_eol_q  <= at_eol;
            s1_eof_q  <= at_eof;
            s1_sum_q  <= sum_d;
            s1_diff_q <= diff_d;
            s1_thr_q  <= thr_d;
            s1_gray_q <= gray_d;
        end else if (adv) begin
            v1_q <= 1'b0;
        end
    end

    // Stage 2: registered outputs, held while the sink stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_valid_out <= 1'b0;
            pixel_out       <= '0;
            pixel_sof_out   <= 1'b0;
            pixel_eol_out   <= 1'b0;
            pixel_eof_out   <= 1'b0;
        end else if (adv) begin
            pixel_valid_out <= v1_q;
            pixel_out       <= final_d;
            pixel_sof_out   <= v1_q & s1_sof_q;
            pixel_eol_out   <= v1_q & s1_eol_q;
            pixel_eof_out   <= v1_q & s1_eof_q;
        end
    end

endmodule

// File: tb/tb_image_stream_processor.sv
// Scoreboard bench for image_stream_processor on a 4x2 frame with random stimulus.
module tb_image_stream_processor;
    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  operation_select;
    logic [7:0]  threshold_value, brightness_value;
    logic        pixel_valid_in, pixel_ready_out;
    logic [23:0] pixel_in;
    logic        pixel_valid_out, pixel_ready_in;
    logic [23:0] pixel_out;
    logic        pixel_sof_out, pixel_eol_out, pixel_eof_out;
    logic [15:0] frame_count;

    image_stream_processor #(
        .CH_W(8), .NUM_CH(3), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk(clk), .rst(rst),
        .operation_select(operation_select),
        .threshold_value(threshold_value),
        .brightness_value(brightness_value),
        .pixel_valid_in(pixel_valid_in), .pixel_ready_out(pixel_ready_out),
        .pixel_in(pixel_in),
        .pixel_valid_out(pixel_valid_out), .pixel_ready_in(pixel_ready_in),
        .pixel_out(pixel_out),
        .pixel_sof_out(pixel_sof_out), .pixel_eol_out(pixel_eol_out),
        .pixel_eof_out(pixel_eof_out),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] pix;
        logic        sof, eol, eof;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    int          acc_cnt = 0, out_cnt = 0, pos = 0, exp_fc = 0;
    int          rdy_mode = 0;
    logic [2:0]  f_op = 3'd5;
    int          f_thr = 0, f_br = 0;
    bit          stalled = 1'b0;
    logic [26:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: each op computed straight from its arithmetic definition.
    function automatic logic [23:0] model(input logic [23:0] px, input logic [2:0] op,
                                          input int thr, input int br);
        int c[3];
        int r[3];
        int y;
        c[0] = int'(px[23:16]);
        c[1] = int'(px[15:8]);
        c[2] = int'(px[7:0]);
        y = (77 * c[0] + 150 * c[1] + 29 * c[2]) / 256;
        for (int i = 0; i < 3; i++) begin
            case (op)
                3'd0:    r[i] = 255 - c[i];
                3'd1:    r[i] = (c[i] >= thr) ? 255 : 0;
                3'd2:    r[i] = (c[i] + br > 255) ? 255 : c[i] + br;
                3'd3:    r[i] = y;
                3'd4:    r[i] = (c[i] < br) ? 0 : c[i] - br;
                default: r[i] = c[i];
            endcase
        end
        return {8'(r[0]), 8'(r[1]), 8'(r[2])};
    endfunction

    // Sink readiness: always, or a coin flip each cycle
    initial begin
        pixel_ready_in = 1'b1;
        forever begin
            @(negedge clk);
            pixel_ready_in = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // One driver cycle; checks ready_out against pipe occupancy just before the edge.
    task automatic step(input bit valid, input logic [23:0] px, input bit cfg_new,
                        input logic [2:0] op, input logic [7:0] thr, input logic [7:0] br,
                        input bit scramble, output bit acc);
        @(negedge clk);
        pixel_valid_in = valid;
        if (valid) pixel_in = px;
        if (cfg_new) begin
            operation_select = op;
            threshold_value  = thr;
            brightness_value = br;
        end else if (scramble) begin
            operation_select = 3'($urandom);
            threshold_value  = 8'($urandom);
            brightness_value = 8'($urandom);
        end
        #3;
        check("ready_out", 64'(pixel_ready_out),
              64'(!((acc_cnt - out_cnt) == 2 && !pixel_ready_in)));
        acc = valid && pixel_ready_out;
    endtask

    task automatic send_pixel(input logic [23:0] px, input logic [2:0] op, input logic [7:0] thr,
                              input logic [7:0] br, input bit scramble, input bit gaps);
        bit   acc;
        int   tries;
        exp_t e;
        repeat (gaps ? $urandom_range(0, 2) : 0) step(1'b0, px, pos == 0, op, thr, br, scramble, acc);
        acc   = 1'b0;
        tries = 0;
        while (!acc) begin
            step(1'b1, px, pos == 0, op, thr, br, scramble, acc);
            tries++;
            if (!acc && tries > 100) begin
                $display("FAIL accept_timeout: got no accept want accept");
                $fatal(1, "input never accepted");
            end
        end
        if (pos == 0) begin
            f_op  = op;
            f_thr = int'(thr);
            f_br  = int'(br);
        end
        e.pix = model(px, f_op, f_thr, f_br);
        e.sof = (pos == 0);
        e.eol = (pos % W == W - 1);
        e.eof = (pos == W * H - 1);
        sb.push_back(e);
        acc_cnt++;
        pos = (pos + 1) % (W * H);
    endtask

    task automatic send_frame(input logic [2:0] op, input logic [7:0] thr, input logic [7:0] br,
                              input logic [23:0] first, input bit same, input bit scramble,
                              input bit gaps, input int n);
        for (int i = 0; i < n; i++)
            send_pixel((i == 0 || same) ? first : 24'($urandom), op, thr, br, scramble, gaps);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 24'd0, pos == 0, f_op, 8'(f_thr), 8'(f_br), 1'b0, acc);
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks stall stability
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                check("frame_count", 64'(frame_count), 64'(exp_fc));
                if (stalled) begin
                    check("hold_valid", 64'(pixel_valid_out), 64'd1);
                    check("hold_data", 64'({pixel_out, pixel_sof_out, pixel_eol_out, pixel_eof_out}),
                          64'(held));
                end
                if (pixel_valid_out && pixel_ready_in) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %h want none", pixel_out);
                    end else begin
                        e = sb.pop_front();
                        check("pixel", 64'(pixel_out), 64'(e.pix));
                        check("markers", 64'({pixel_sof_out, pixel_eol_out, pixel_eof_out}),
                              64'({e.sof, e.eol, e.eof}));
                        if (e.eof) exp_fc = (exp_fc + 1) & 16'hFFFF;
                    end
                    out_cnt++;
                    stalled = 1'b0;
                end else if (pixel_valid_out) begin
                    stalled = 1'b1;
                    held    = {pixel_out, pixel_sof_out, pixel_eol_out, pixel_eof_out};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic mid_reset();
        @(negedge clk);
        pixel_valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid_out", 64'(pixel_valid_out), 64'd0);
        check("rst_ready_out", 64'(pixel_ready_out), 64'd1);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        sb.delete();
        acc_cnt = 0;
        out_cnt = 0;
        exp_fc  = 0;
        pos     = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        pixel_valid_in   = 1'b0;
        pixel_in         = '0;
        operation_select = '0;
        threshold_value  = '0;
        brightness_value = '0;
        #12;
        check("init_valid_out", 64'(pixel_valid_out), 64'd0);
        check("init_ready_out", 64'(pixel_ready_out), 64'd1);
        check("init_frame_count", 64'(frame_count), 64'd0);
        check("init_markers", 64'({pixel_sof_out, pixel_eol_out, pixel_eof_out}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed frames
        send_frame(3'd0, 8'd0,   8'd0,  24'h102030, 1'b1, 1'b0, 1'b0, 8);
        send_frame(3'd2, 8'd0,   8'd80, 24'hC81000, 1'b0, 1'b0, 1'b0, 8);
        send_frame(3'd4, 8'd0,   8'd80, 24'hC81000, 1'b0, 1'b0, 1'b0, 8);
        send_frame(3'd3, 8'd0,   8'd0,  24'hFF0000, 1'b0, 1'b0, 1'b0, 8);
        send_frame(3'd1, 8'd128, 8'd0,  24'h807F00, 1'b0, 1'b0, 1'b0, 8);

        // Backpressure, then mid-frame config churn across two frames
        rdy_mode = 1;
        send_frame(3'd5, 8'd0, 8'd0, 24'($urandom), 1'b0, 1'b0, 1'b0, 8);
        send_frame(3'd0, 8'd0, 8'd0, 24'($urandom), 1'b0, 1'b1, 1'b1, 8);
        send_frame(3'd2, 8'd0, 8'($urandom), 24'($urandom), 1'b0, 1'b1, 1'b0, 8);

        // Reset with a partial frame in flight
        send_frame(3'd0, 8'd0, 8'd0, 24'($urandom), 1'b0, 1'b0, 1'b0, 3);
        mid_reset();

        for (int f = 0; f < 30; f++) begin
            rdy_mode = $urandom_range(0, 1);
            send_frame(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 24'($urandom),
                       1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8);
        end

        rdy_mode = 0;
        guard    = 0;
        while (sb.size() != 0 && guard < 100) begin
            idle(1);
            guard++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
